// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
// Shared MIPS-subset encoding constants used by both the instruction
// decoder and the instruction encoder: tuple kind codes, ALU op codes,
// primary opcodes and R-type funct codes.
package cpu_isa_pkg;

  // Tuple kind, as carried on in_kind
  typedef enum logic [1:0] {
    KIND_R  = 2'b00,
    KIND_I  = 2'b01,
    KIND_LW = 2'b10,
    KIND_SW = 2'b11
  } kind_e;

  // ALU op codes, identical to what the decoder emits
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_e;

  // Primary opcodes
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLLV = 6'b000100;

endpackage

// File: rtl/inst_encode_word.sv
// inst_encode_word
// Purely combinational encoder from an instruction field tuple to a
// 32-bit MIPS-subset word.
// Ports:
//   kind    in  2   tuple kind (R / I-arith / LW / SW)
//   alu_op  in  3   ALU op code
//   rs      in  5   rs field, placed at [25:21]
//   rt      in  5   rt field, placed at [20:16]
//   rd      in  5   rd field, placed at [15:11] (R-type only)
//   imm     in  16  immediate, placed at [15:0] (I/LW/SW only)
//   word    out 32  encoded instruction
//   illegal out 1   I-arith with an ALU op that has no immediate form
module inst_encode_word
  import cpu_isa_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] funct;
  logic [5:0] opcode;

  // Select funct/opcode by kind and ALU op, then assemble the word.
  // Only ADD/AND/XOR/SLTU have immediate forms; the rest flag illegal.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    funct   = '0;
    opcode  = '0;
    case (kind)
      KIND_R: begin
        case (alu_op)
          ALU_ADD:  funct = FN_ADD;
          ALU_SUB:  funct = FN_SUB;
          ALU_AND:  funct = FN_AND;
          ALU_OR:   funct = FN_OR;
          ALU_XOR:  funct = FN_XOR;
          ALU_NOR:  funct = FN_NOR;
          ALU_SLTU: funct = FN_SLTU;
          default:  funct = FN_SLLV;
        endcase
        word = {OP_R, rs, rt, rd, 5'd0, funct};
      end
      KIND_I: begin
        case (alu_op)
          ALU_ADD:  opcode = OP_ADDI;
          ALU_AND:  opcode = OP_ANDI;
          ALU_XOR:  opcode = OP_XORI;
          ALU_SLTU: opcode = OP_SLTIU;
          default:  illegal = 1'b1;
        endcase
        word = {opcode, rs, rt, imm};
      end
      KIND_LW: word = {OP_LW, rs, rt, imm};
      default: word = {OP_SW, rs, rt, imm};
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
// Accepts instruction field tuples over valid/ready, encodes them and
// writes the words to consecutive instruction memory addresses so a test
// program can be loaded before the CPU runs.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                pulse; begins or restarts a load session
//   in_valid/in_ready    tuple handshake
//   in_kind..in_imm      tuple fields; in_last marks the final tuple
//   mem_we/addr/wdata    instruction memory write port (registered)
//   word_count           words written this session (saturates at DEPTH)
//   busy                 session in progress
//   done                 session finished, held until the next start
//   err_illegal          sticky, an illegal tuple was received
module inst_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_alu_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_COUNT = FULL_COUNT - 1'b1;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e            state;
  state_e            next_state;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;

  inst_encode_word u_encode (
    .kind    (in_kind),
    .alu_op  (in_alu_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // A start cycle never accepts a beat, so restart always begins clean
  assign in_ready = (state == LOAD) && !start && (word_count < FULL_COUNT);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Leave LOAD on the accepted last beat, or on the legal beat that fills
  // the memory; illegal beats never consume a slot.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        if (start) next_state = LOAD;
        else if (word_count == FULL_COUNT) next_state = DONE;
        else if (accept && (in_last || (!enc_illegal && word_count == LAST_COUNT)))
          next_state = DONE;
      end
      DONE: if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Write register and session counters. A write registered in the cycle
  // before start still appears on the port during the start cycle; the
  // counters reset at the start edge. done follows the final write by a
  // cycle, or rises directly when the final beat was illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      next_addr   <= BASE;
      word_count  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        next_addr   <= BASE;
        word_count  <= '0;
        done        <= 1'b0;
        err_illegal <= 1'b0;
      end else begin
        if (accept) begin
          if (enc_illegal) begin
            err_illegal <= 1'b1;
            if (in_last) done <= 1'b1;
          end else begin
            mem_we     <= 1'b1;
            mem_addr   <= next_addr;
            mem_wdata  <= enc_word;
            next_addr  <= next_addr + 1'b1;
            word_count <= word_count + 1'b1;
          end
        end
        if (state == DONE) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
// Directed bench for inst_encoder: a default-size instance (ADDR_W=6)
// and a small instance (ADDR_W=2) sharing all inputs, the small one used
// for the memory-full case. Expected values are hand-encoded words.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_kind = '0;
  logic [2:0]  in_alu_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, busy, done, err_illegal;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_err_illegal;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_word_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_alu_op(in_alu_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy),
    .done(done), .err_illegal(err_illegal)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_kind(in_kind), .in_alu_op(in_alu_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .word_count(s_word_count), .busy(s_busy),
    .done(s_done), .err_illegal(s_err_illegal)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] kind,
                               input logic [2:0] alu, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [15:0] imm, input logic last);
    in_valid  = valid;
    in_kind   = kind;
    in_alu_op = alu;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_last   = last;
  endtask

  // Advance one clock; returns on the falling edge so outputs are stable
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    $display("[TB] inst_encoder bench starting");
    @(negedge clk);

    // Reset values
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_word_count", 64'(word_count), 64'd0);
    checkOutput("rst_flags", 64'({busy, done, err_illegal, in_ready}), 64'd0);
    rst_n = 1'b1;
    tick();

    // R-type add
    pulseStart();
    checkOutput("r_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1, 2'b00, 3'b100, 5'd1, 5'd2, 5'd3, 16'hABCD, 1'b0);
    #1 checkOutput("r_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    checkOutput("r_we", 64'(mem_we), 64'd1);
    checkOutput("r_addr", 64'(mem_addr), 64'd0);
    checkOutput("r_wdata", 64'(mem_wdata), 64'h00221820);
    checkOutput("r_count", 64'(word_count), 64'd1);
    tick();
    checkOutput("r_we_one_cycle", 64'(mem_we), 64'd0);

    // I-arith and memory beats back-to-back
    pulseStart();
    applyStimulus(1'b1, 2'b01, 3'b100, 5'd4, 5'd5, 5'd9, 16'hFFFF, 1'b0);
    tick();
    checkOutput("b1_wdata", 64'(mem_wdata), 64'h2085FFFF);
    checkOutput("b1_addr", 64'(mem_addr), 64'd0);
    applyStimulus(1'b1, 2'b10, 3'b011, 5'd29, 5'd8, 5'd7, 16'h0004, 1'b0);
    tick();
    checkOutput("b2_we", 64'(mem_we), 64'd1);
    checkOutput("b2_wdata", 64'(mem_wdata), 64'h8FA80004);
    checkOutput("b2_addr", 64'(mem_addr), 64'd1);
    applyStimulus(1'b1, 2'b11, 3'b011, 5'd29, 5'd8, 5'd7, 16'h0004, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    checkOutput("b3_we", 64'(mem_we), 64'd1);
    checkOutput("b3_wdata", 64'(mem_wdata), 64'hAFA80004);
    checkOutput("b3_addr", 64'(mem_addr), 64'd2);
    tick();
    checkOutput("b3_done", 64'(done), 64'd1);
    checkOutput("b3_busy", 64'(busy), 64'd0);
    checkOutput("b3_count", 64'(word_count), 64'd3);

    // Illegal tuple, then legal beats keep the same address sequence
    pulseStart();
    checkOutput("restart_clears_done", 64'(done), 64'd0);
    applyStimulus(1'b1, 2'b01, 3'b001, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0);
    tick();
    checkOutput("ill_we", 64'(mem_we), 64'd0);
    checkOutput("ill_err", 64'(err_illegal), 64'd1);
    checkOutput("ill_count", 64'(word_count), 64'd0);
    applyStimulus(1'b1, 2'b01, 3'b000, 5'd1, 5'd2, 5'd0, 16'h00F0, 1'b0);
    tick();
    checkOutput("andi_we", 64'(mem_we), 64'd1);
    checkOutput("andi_addr", 64'(mem_addr), 64'd0);
    checkOutput("andi_wdata", 64'(mem_wdata), 64'h302200F0);
    checkOutput("err_sticky", 64'(err_illegal), 64'd1);
    applyStimulus(1'b1, 2'b00, 3'b111, 5'd3, 5'd4, 5'd5, 16'hFFFF, 1'b0);
    tick();
    checkOutput("sllv_wdata", 64'(mem_wdata), 64'h00642804);
    checkOutput("sllv_addr", 64'(mem_addr), 64'd1);
    applyStimulus(1'b1, 2'b01, 3'b110, 5'd0, 5'd31, 5'd6, 16'h0001, 1'b0);
    tick();
    checkOutput("sltiu_wdata", 64'(mem_wdata), 64'h2C1F0001);
    checkOutput("sltiu_count", 64'(word_count), 64'd3);

    // Restart with a write pending: it completes, then counters clear
    applyStimulus(1'b1, 2'b00, 3'b100, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    tick();
    start = 1'b1;
    #1;
    checkOutput("rs_ready_in_start", 64'(in_ready), 64'd0);
    checkOutput("rs_pending_we", 64'(mem_we), 64'd1);
    checkOutput("rs_pending_addr", 64'(mem_addr), 64'd3);
    tick();
    start = 1'b0;
    checkOutput("rs_no_accept", 64'(mem_we), 64'd0);
    checkOutput("rs_count", 64'(word_count), 64'd0);
    checkOutput("rs_err_cleared", 64'(err_illegal), 64'd0);
    checkOutput("rs_busy", 64'(busy), 64'd1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    checkOutput("rs_first_addr", 64'(mem_addr), 64'd0);
    checkOutput("rs_first_count", 64'(word_count), 64'd1);

    // Memory full on the ADDR_W=2 instance: 5 beats offered, 4 written
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b00, 3'b100, 5'd1, 5'd2, 5'(i), 16'h0, 1'b0);
      tick();
      if (i < 4) begin
        checkOutput($sformatf("full_we%0d", i), 64'(s_mem_we), 64'd1);
        checkOutput($sformatf("full_addr%0d", i), 64'(s_mem_addr), 64'(i));
        checkOutput($sformatf("full_wdata%0d", i), 64'(s_mem_wdata),
                    64'(32'h00220020 | (i << 11)));
      end else begin
        checkOutput("full_no_fifth", 64'(s_mem_we), 64'd0);
        checkOutput("full_done", 64'(s_done), 64'd1);
      end
      if (i == 3) checkOutput("full_ready_low", 64'(s_in_ready), 64'd0);
    end
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    tick();
    checkOutput("full_count", 64'(s_word_count), 64'd4);
    checkOutput("full_busy", 64'(s_busy), 64'd0);

    // Async reset mid-session with a write on the port
    pulseStart();
    applyStimulus(1'b1, 2'b10, 3'b000, 5'd2, 5'd3, 5'd0, 16'h0010, 1'b0);
    tick();
    checkOutput("mr_pre_we", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_we", 64'(mem_we), 64'd0);
    checkOutput("mr_addr", 64'(mem_addr), 64'd0);
    checkOutput("mr_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("mr_count", 64'(word_count), 64'd0);
    checkOutput("mr_flags", 64'({busy, done, err_illegal, in_ready}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mr_ready_after", 64'(in_ready), 64'd0);
    checkOutput("mr_no_write", 64'(mem_we), 64'd0);
    applyStimulus(1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the CPU's instruction decoder. Accepts instruction field tuples (kind, ALU op code, rs/rt/rd, imm) over a valid/ready handshake and encodes each one into a 32-bit MIPS-subset word. Writes the encoded words to consecutive addresses of the instruction memory write port. Used to load test programs into instruction memory before the CPU runs.

Parameters:
ADDR_W, 6, instruction memory address width; capacity DEPTH = 2**ADDR_W words
BASE_ADDR, 0, first memory address written after start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts a load session
in_valid  in  1  field tuple valid
in_ready  out  1  encoder can accept a tuple
in_kind  in  2  00=R-type, 01=I-arith, 10=LW, 11=SW
in_alu_op  in  3  ALU op code, same codes the decoder emits
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-type only)
in_imm  in  16  immediate (I/LW/SW only)
in_last  in  1  marks the final tuple of the program
mem_we  out  1  instruction memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  encoded instruction word
word_count  out  ADDR_W+1  number of words written this session
busy  out  1  state==LOAD
done  out  1  session finished; held until start
err_illegal  out  1  sticky; an illegal tuple was received

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, done=0, err_illegal=0.
- States:
  - IDLE: start -> LOAD.
  - LOAD: in_last accepted, or word_count reaches DEPTH -> DONE. start -> LOAD (restart).
  - DONE: start -> LOAD.
- On every start: next address = BASE_ADDR, word_count=0, done=0, err_illegal=0.
- in_ready = (state==LOAD) && !start && (word_count < DEPTH). It is combinational from state and start. A beat is accepted when in_valid && in_ready at the rising edge.
- Latency: an accepted legal beat drives mem_we=1 for exactly one cycle, on the cycle after acceptance. In that cycle mem_addr holds the write address and mem_wdata the word. The write address then increments and word_count increments. Back-to-back beats give one write per cycle.
- Address wrap: address arithmetic is modulo DEPTH. word_count never exceeds DEPTH. With word_count==DEPTH, in_ready=0 and the state goes to DONE.
- Encoding, R-type (kind 00): opcode 000000, shamt 0. funct by alu_op: 100->100000, 101->100010, 000->100100, 001->100101, 010->100110, 011->100111, 110->101011, 111->000100. in_imm is ignored.
- Encoding, I-arith (kind 01): opcode by alu_op: 100->001000, 000->001100, 010->001110, 110->001011. in_rd is ignored.
- Encoding, LW (kind 10): opcode 100011. SW (kind 11): opcode 101011. in_alu_op and in_rd are ignored.
- Field placement: rs in bits [25:21], rt in [20:16], rd in [15:11], imm in [15:0].
- Illegal tuple: kind 01 with alu_op in {001, 011, 101, 111}. The beat is accepted but nothing is written and word_count is unchanged; err_illegal=1 on the next cycle. If in_last is set on an illegal beat, the state still goes to DONE.
- done goes high in the cycle after the final write (or after the final accepted beat if it was illegal). busy=0 in IDLE and DONE.
- start in the same cycle as a pending write: the pending write still completes, then the counters reset.
- Async reset mid-session aborts immediately; no partial write strobe is produced.

Decomposition:
- Shared package cpu_isa_pkg:
  - kind codes;
  - ALU_OP codes;
  - opcode constants (R 000000, ADDI, ANDI, XORI, SLTIU, LW, SW);
  - funct constants.
  The decoder uses this package too.
- One combinational sub-module, inst_encode_word: inputs are the fields, outputs are word[31:0] and illegal. The top level holds the FSM, handshake, counters and write register.

Test Plan:
- R add: start, then {kind 00, alu 100, rs1, rt2, rd3} -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, word_count=1.
- I-arith and memory back-to-back:
  - beat 1 {01, 100, rs4, rt5, imm 0xFFFF} -> 0x2085FFFF at address 0;
  - beat 2 {10, rs29, rt8, imm 4} -> 0x8FA80004 at address 1;
  - beat 3 {11, same fields, in_last} -> 0xAFA80004 at address 2.
  After beat 3: done=1, busy=0.
- Illegal: {01, alu 001} -> no mem_we, err_illegal=1, word_count unchanged. The next legal beat is still written at the same address.
- Full, with ADDR_W=2: 5 valid beats, no in_last -> exactly 4 writes at addresses 0..3, in_ready=0 after the 4th acceptance, done=1, word_count=4.
- Restart: start while busy with 2 words written -> word_count=0, next write at BASE_ADDR, err_illegal cleared. A beat presented in the start cycle is not accepted.
- Reset mid-session: pull rst_n low during streaming -> all outputs return to reset values immediately. in_ready stays 0 until start.
